// File: rtl/ofm_rd_pkg.sv
// Shared constants and types for the layer-2 Ofm read side.
package ofm_rd_pkg;

  localparam int unsigned ADDR_W         = 8;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;

  localparam int unsigned LANE_CNT = 4;
  localparam int unsigned LANE1    = 0;
  localparam int unsigned LANE2    = 1;
  localparam int unsigned LANE3    = 2;
  localparam int unsigned LANE4    = 3;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN,
    FIN
  } state_t;

endpackage

// File: rtl/ofm_byte_packer.sv
// One lane's byte pack slots plus the output word register.
module ofm_byte_packer #(
  parameter int unsigned BYTE_W         = ofm_rd_pkg::BYTE_W,
  parameter int unsigned BYTES_PER_WORD = ofm_rd_pkg::BYTES_PER_WORD,
  parameter int unsigned IDX_W          = $clog2(ofm_rd_pkg::BYTES_PER_WORD)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             cap_en,
  input  logic [IDX_W-1:0]                 cap_idx,
  input  logic [BYTE_W-1:0]                din,
  input  logic                             load,
  output logic [BYTE_W*BYTES_PER_WORD-1:0] word
);

  logic [BYTE_W*BYTES_PER_WORD-1:0] pack;

  // Slots are zeroed on every load so a short final group reads back with zero upper bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      pack <= '0;
      word <= '0;
    end else if (load) begin
      word <= pack;
      pack <= '0;
    end else if (clear) begin
      pack <= '0;
    end else if (cap_en) begin
      for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
        if (cap_idx == IDX_W'(k)) pack[k*BYTE_W +: BYTE_W] <= din;
      end
    end
  end

endmodule

// File: rtl/ofm_word_reader.sv
// Sweeps the four Ofm byte memories in lockstep and emits packed 32-bit words per lane.
module ofm_word_reader #(
  parameter int unsigned ADDR_W         = ofm_rd_pkg::ADDR_W,
  parameter int unsigned BYTE_W         = ofm_rd_pkg::BYTE_W,
  parameter int unsigned BYTES_PER_WORD = ofm_rd_pkg::BYTES_PER_WORD
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [ADDR_W:0]                  numBytes,
  output logic                             rden,
  output logic [ADDR_W-1:0]                rdaddr,
  input  logic [BYTE_W-1:0]                rdData1,
  input  logic [BYTE_W-1:0]                rdData2,
  input  logic [BYTE_W-1:0]                rdData3,
  input  logic [BYTE_W-1:0]                rdData4,
  output logic [BYTE_W*BYTES_PER_WORD-1:0] Dataofm1,
  output logic [BYTE_W*BYTES_PER_WORD-1:0] Dataofm2,
  output logic [BYTE_W*BYTES_PER_WORD-1:0] Dataofm3,
  output logic [BYTE_W*BYTES_PER_WORD-1:0] Dataofm4,
  output logic                             dataValid,
  input  logic                             dataReady,
  output logic                             busy,
  output logic                             done
);
  import ofm_rd_pkg::*;

  localparam int unsigned WORD_W = BYTE_W * BYTES_PER_WORD;
  localparam int unsigned IDX_W  = $clog2(BYTES_PER_WORD);
  localparam int unsigned CNT_W  = IDX_W + 1;
  localparam logic [CNT_W-1:0] GRP_N = CNT_W'(BYTES_PER_WORD);

  state_t            state, state_nx;
  logic [ADDR_W:0]   num_q;
  logic [ADDR_W:0]   num_m1;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  iss_grp;
  logic [CNT_W-1:0]  cap_idx;
  logic              issued_all;
  logic              pend;
  logic              pend_last;
  logic              last_capt;
  logic              out_valid;
  logic              done_q;
  logic              grp_full;
  logic              at_last;
  logic              issue;
  logic              transfer;
  logic              accept;
  logic              start_go;

  assign num_m1   = num_q - 1'b1;
  assign at_last  = ({1'b0, addr} == num_m1);
  assign accept   = out_valid && dataReady;
  // A group closes on its 4th byte, or early once the sweep's final byte has landed.
  assign grp_full = (cap_idx == GRP_N) || (last_capt && (cap_idx != '0));

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    transfer = 1'b0;
    start_go = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_go = 1'b1;
          state_nx = (numBytes == '0) ? FIN : FILL;
        end
      end
      FILL: begin
        issue    = (iss_grp < GRP_N) && !issued_all && !grp_full;
        transfer = grp_full && (!out_valid || dataReady);
        if (transfer && last_capt) state_nx = DRAIN;
      end
      DRAIN: begin
        if (accept) state_nx = FIN;
      end
      FIN: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      num_q      <= '0;
      addr       <= '0;
      iss_grp    <= '0;
      cap_idx    <= '0;
      issued_all <= 1'b0;
      pend       <= 1'b0;
      pend_last  <= 1'b0;
      last_capt  <= 1'b0;
      out_valid  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state     <= state_nx;
      done_q    <= (state == FIN);
      pend      <= issue;
      pend_last <= issue && at_last;
      if (start_go) begin
        num_q      <= numBytes;
        addr       <= '0;
        iss_grp    <= '0;
        cap_idx    <= '0;
        issued_all <= 1'b0;
        last_capt  <= 1'b0;
      end else begin
        if (issue) begin
          iss_grp <= iss_grp + 1'b1;
          // Hold the address on the final byte rather than wrapping past it.
          if (at_last) issued_all <= 1'b1;
          else         addr       <= addr + 1'b1;
        end
        if (pend) begin
          cap_idx <= cap_idx + 1'b1;
          if (pend_last) last_capt <= 1'b1;
        end
        if (transfer) begin
          iss_grp <= '0;
          cap_idx <= '0;
        end
      end
      if (transfer)    out_valid <= 1'b1;
      else if (accept) out_valid <= 1'b0;
    end
  end

  logic [BYTE_W-1:0] lane_in   [LANE_CNT];
  logic [WORD_W-1:0] lane_word [LANE_CNT];

  assign lane_in[LANE1] = rdData1;
  assign lane_in[LANE2] = rdData2;
  assign lane_in[LANE3] = rdData3;
  assign lane_in[LANE4] = rdData4;

  for (genvar g = 0; g < LANE_CNT; g++) begin : g_lane
    ofm_byte_packer #(
      .BYTE_W        (BYTE_W),
      .BYTES_PER_WORD(BYTES_PER_WORD),
      .IDX_W         (IDX_W)
    ) u_packer (
      .clk    (clk),
      .rst    (rst),
      .clear  (start_go),
      .cap_en (pend),
      .cap_idx(cap_idx[IDX_W-1:0]),
      .din    (lane_in[g]),
      .load   (transfer),
      .word   (lane_word[g])
    );
  end

  assign Dataofm1  = lane_word[LANE1];
  assign Dataofm2  = lane_word[LANE2];
  assign Dataofm3  = lane_word[LANE3];
  assign Dataofm4  = lane_word[LANE4];
  assign rden      = issue;
  assign rdaddr    = addr;
  assign dataValid = out_valid;
  assign busy      = (state != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_ofm_word_reader.sv
// Scoreboard bench for ofm_word_reader: memory model, randomized backpressure, queue-based word checking.
module tb_ofm_word_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  numBytes = '0;
  logic        rden;
  logic [7:0]  rdaddr;
  logic [7:0]  rdData1, rdData2, rdData3, rdData4;
  logic [31:0] Dataofm1, Dataofm2, Dataofm3, Dataofm4;
  logic        dataValid;
  logic        dataReady = 1'b1;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  logic [7:0]   mem [4][256];
  logic [127:0] exp_q [$];
  logic [127:0] last_word;
  logic [127:0] prev_word;
  bit           prev_hold = 1'b0;
  int           exp_addr = 0;
  int           rden_count = 0;
  int           last_addr = -1;
  int           words_seen = 0;
  int           done_count = 0;

  int ready_mode = 0;
  int stall_left = 0;
  bit stall_armed = 1'b0;

  always #5 clk = ~clk;

  ofm_word_reader #(
    .ADDR_W(8),
    .BYTE_W(8),
    .BYTES_PER_WORD(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .numBytes(numBytes),
    .rden(rden), .rdaddr(rdaddr),
    .rdData1(rdData1), .rdData2(rdData2), .rdData3(rdData3), .rdData4(rdData4),
    .Dataofm1(Dataofm1), .Dataofm2(Dataofm2), .Dataofm3(Dataofm3), .Dataofm4(Dataofm4),
    .dataValid(dataValid), .dataReady(dataReady), .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memories return data one cycle after rden; garbage otherwise.
  always @(posedge clk) begin
    if (rden) begin
      rdData1 <= mem[0][rdaddr];
      rdData2 <= mem[1][rdaddr];
      rdData3 <= mem[2][rdaddr];
      rdData4 <= mem[3][rdaddr];
    end else begin
      rdData1 <= 8'($urandom);
      rdData2 <= 8'($urandom);
      rdData3 <= 8'($urandom);
      rdData4 <= 8'($urandom);
    end
  end

  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) dataReady = 1'b1;
    else if (ready_mode == 1) dataReady = ($urandom_range(0, 2) != 0);
    else begin
      if (stall_armed && dataValid) begin
        stall_armed = 1'b0;
        stall_left  = 20;
      end
      dataReady = (stall_left == 0);
      if (stall_left > 0) stall_left--;
    end
  end

  // Monitor: pops expected words on every handshake and checks read addresses.
  always @(negedge clk) begin
    logic [127:0] cur;
    logic [127:0] exp_w;
    cur = {Dataofm4, Dataofm3, Dataofm2, Dataofm1};
    if (rst) begin
      prev_hold = 1'b0;
      exp_addr  = 0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", dataValid, 1);
        check("hold_stable", cur, prev_word);
      end
      if (rden) begin
        check("rd_addr", rdaddr, exp_addr);
        last_addr = rdaddr;
        exp_addr++;
        rden_count++;
      end
      if (dataValid && dataReady) begin
        if (exp_q.size() == 0) check("unexpected_word", cur, 0);
        else begin
          exp_w = exp_q.pop_front();
          check("word", cur, exp_w);
        end
        last_word = cur;
        words_seen++;
      end
      prev_hold = dataValid && !dataReady;
      prev_word = cur;
      if (done) begin
        done_count++;
        check("done_q_empty", exp_q.size(), 0);
        check("done_valid_low", dataValid, 0);
        check("done_busy_low", busy, 0);
        exp_addr = 0;
      end
    end
  end

  task automatic push_sweep(input int n);
    logic [127:0] w;
    int idx;
    for (int g = 0; g < (n + 3) / 4; g++) begin
      w = '0;
      for (int lane = 0; lane < 4; lane++)
        for (int k = 0; k < 4; k++) begin
          idx = g * 4 + k;
          if (idx < n) w[lane*32 + k*8 +: 8] = mem[lane][idx];
        end
      exp_q.push_back(w);
    end
  endtask

  task automatic start_sweep(input int n);
    @(posedge clk); #1;
    numBytes   = 9'(n);
    start      = 1'b1;
    rden_count = 0;
    push_sweep(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk); #1;
      cyc++;
    end while (!done && cyc < budget);
    check("done_seen", done, 1);
  endtask

  initial begin
    int cyc;
    int w0;
    int d0;
    int n;

    for (int lane = 0; lane < 4; lane++)
      for (int i = 0; i < 256; i++)
        mem[lane][i] = (i < 16) ? 8'(16 * lane + i) : 8'($urandom);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    check("rst_rden", rden, 0);
    check("rst_rdaddr", rdaddr, 0);
    check("rst_valid", dataValid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", {Dataofm4, Dataofm3, Dataofm2, Dataofm1}, 0);

    // Single word: exact cycle-level timing.
    @(posedge clk); #1;
    numBytes = 9'd4;
    start    = 1'b1;
    rden_count = 0;
    push_sweep(4);
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk); #1;
      check($sformatf("t1_rden_c%0d", c), rden, (c >= 1 && c <= 4));
      if (c >= 1 && c <= 4) check($sformatf("t1_addr_c%0d", c), rdaddr, c - 1);
      check($sformatf("t1_valid_c%0d", c), dataValid, (c == 7));
      check($sformatf("t1_busy_c%0d", c), busy, (c >= 1 && c <= 8));
      check($sformatf("t1_done_c%0d", c), done, (c == 9));
      if (c == 7) begin
        check("t1_ofm1", Dataofm1, 32'h03020100);
        check("t1_ofm4", Dataofm4, 32'h33323130);
      end
      @(posedge clk); #1;
      start = 1'b0;
    end

    // Partial final group.
    w0 = words_seen;
    start_sweep(6);
    wait_done(80, cyc);
    check("partial_rden", rden_count, 6);
    check("partial_words", words_seen - w0, 2);
    check("partial_ofm1", last_word[31:0], 32'h00000504);

    // Empty range.
    w0 = words_seen;
    start_sweep(0);
    wait_done(20, cyc);
    check("empty_done_cycle", cyc, 2);
    check("empty_rden", rden_count, 0);
    check("empty_words", words_seen - w0, 0);

    // Backpressure: 20-cycle stall after the first valid.
    w0 = words_seen;
    ready_mode  = 2;
    stall_armed = 1'b1;
    start_sweep(12);
    cyc = 0;
    do begin
      @(negedge clk); #1;
      cyc++;
    end while (!dataValid && cyc < 50);
    check("bp_first_valid", dataValid, 1);
    repeat (15) @(negedge clk);
    #1;
    check("bp_rden_stalled", rden_count, 8);
    wait_done(200, cyc);
    check("bp_words", words_seen - w0, 3);
    ready_mode = 0;

    // Full 256-byte range with random backpressure.
    for (int lane = 0; lane < 4; lane++)
      for (int i = 0; i < 256; i++) mem[lane][i] = 8'($urandom);
    w0 = words_seen;
    ready_mode = 1;
    start_sweep(256);
    wait_done(4000, cyc);
    check("full_words", words_seen - w0, 64);
    check("full_rden", rden_count, 256);
    check("full_last_addr", last_addr, 255);
    check("full_no_wrap", rdaddr, 255);
    ready_mode = 0;

    // Reset in cycle 10 of a 16-byte sweep.
    start_sweep(16);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check("mid_rst_outputs",
          {rden, rdaddr, dataValid, busy, done, Dataofm4, Dataofm3, Dataofm2, Dataofm1}, 0);
    w0 = words_seen;
    start_sweep(8);
    wait_done(100, cyc);
    check("post_rst_words", words_seen - w0, 2);
    check("post_rst_rden", rden_count, 8);

    // start while busy must be ignored.
    w0 = words_seen;
    n = $urandom_range(9, 30);
    start_sweep(n);
    @(posedge clk); #1;
    numBytes = 9'($urandom_range(31, 60));
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(300, cyc);
    check("busy_start_words", words_seen - w0, (n + 3) / 4);

    // Back-to-back: start held through FIN, taken once back in IDLE.
    w0 = words_seen;
    d0 = done_count;
    @(posedge clk); #1;
    numBytes   = 9'd5;
    start      = 1'b1;
    rden_count = 0;
    push_sweep(5);
    wait_done(100, cyc);
    push_sweep(5);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100, cyc);
    check("b2b_dones", done_count - d0, 2);
    check("b2b_words", words_seen - w0, 4);
    check("b2b_rden", rden_count, 10);

    // Random sweeps under random backpressure.
    ready_mode = 1;
    for (int t = 0; t < 6; t++) begin
      w0 = words_seen;
      n = $urandom_range(1, 40);
      start_sweep(n);
      wait_done(600, cyc);
      check($sformatf("rand%0d_words", t), words_seen - w0, (n + 3) / 4);
      check($sformatf("rand%0d_rden", t), rden_count, n);
    end
    ready_mode = 0;

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
